// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl: frame-aligned capture sequencer driving DMA start, pixel gate, status and frame-rate report
module cam_capture_ctrl #(
    parameter int unsigned CLK_FREQ_HZ   = 100000000,
    parameter int unsigned DRAIN_TIMEOUT = 1048576
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trigger_capture_frame,
    input  logic        continuous_capture_frame,
    input  logic        cam_dma_init_done,
    input  logic        frame_start,
    input  logic        frame_end,
    input  logic        dma_done,
    output logic        dma_start,
    output logic        pixel_gate,
    output logic [31:0] cam_dma_status,
    output logic [31:0] frames_per_second
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, CAPTURE = 2'd2, DRAIN = 2'd3} state_t;
    localparam int unsigned WIN_W = $clog2(CLK_FREQ_HZ);
    localparam int unsigned DRN_W = $clog2(DRAIN_TIMEOUT + 1);

    state_t             state_q, state_d;
    logic               trig_q, trig_d;
    logic               edge_en_q, edge_en_d;
    logic               single_pending_q, single_pending_d;
    logic               drain_timeout_q, drain_timeout_d;
    logic               dma_start_q, dma_start_d;
    logic               pixel_gate_q, pixel_gate_d;
    logic [7:0]         overrun_cnt_q, overrun_cnt_d;
    logic [15:0]        frames_captured_q, frames_captured_d;
    logic [DRN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic [31:0]        fps_acc_q, fps_acc_d;
    logic [31:0]        fps_q, fps_d;
    logic               want;
    logic               wrap;
    logic [31:0]        fps_next;

    always_comb begin
        trig_d    = trigger_capture_frame;
        // edge detection is held off for one cycle so a trigger held through reset is not an edge
        edge_en_d = 1'b1;
        want      = single_pending_q | continuous_capture_frame;
        // pixel_gate trails the state by one cycle; its low value marks the first CAPTURE cycle
        pixel_gate_d      = state_q == CAPTURE;
        dma_start_d       = (state_q == CAPTURE) & ~pixel_gate_q;
        single_pending_d  = (trigger_capture_frame & ~trig_q & edge_en_q) | (single_pending_q & ~dma_start_d);
        state_d           = state_q;
        overrun_cnt_d     = overrun_cnt_q;
        frames_captured_d = frames_captured_q;
        drain_timeout_d   = drain_timeout_q;
        drain_cnt_d       = '0;
        case (state_q)
            IDLE: state_d = (cam_dma_init_done & want) ? ARM : IDLE;
            ARM: begin
                if (!cam_dma_init_done || !want) state_d = IDLE;
                else if (frame_start) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (frame_end) begin
                    state_d = DRAIN;
                end else if (frame_start) begin
                    state_d       = DRAIN;
                    overrun_cnt_d = (&overrun_cnt_q) ? overrun_cnt_q : overrun_cnt_q + 8'd1;
                end
            end
            DRAIN: begin
                if (dma_done) begin
                    frames_captured_d = frames_captured_q + 16'd1;
                    state_d           = (cam_dma_init_done & want) ? ARM : IDLE;
                end else if (drain_cnt_q == DRN_W'(DRAIN_TIMEOUT - 1)) begin
                    drain_timeout_d = 1'b1;
                    state_d         = IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        wrap      = win_cnt_q == WIN_W'(CLK_FREQ_HZ - 1);
        win_cnt_d = wrap ? '0 : win_cnt_q + 1'b1;
        fps_next  = (frame_start & ~&fps_acc_q) ? fps_acc_q + 32'd1 : fps_acc_q;
        fps_acc_d = wrap ? '0 : fps_next;
        fps_d     = wrap ? fps_next : fps_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= IDLE;
            trig_q            <= 1'b0;
            edge_en_q         <= 1'b0;
            single_pending_q  <= 1'b0;
            drain_timeout_q   <= 1'b0;
            dma_start_q       <= 1'b0;
            pixel_gate_q      <= 1'b0;
            overrun_cnt_q     <= '0;
            frames_captured_q <= '0;
            drain_cnt_q       <= '0;
            win_cnt_q         <= '0;
            fps_acc_q         <= '0;
            fps_q             <= '0;
        end else begin
            state_q           <= state_d;
            trig_q            <= trig_d;
            edge_en_q         <= edge_en_d;
            single_pending_q  <= single_pending_d;
            drain_timeout_q   <= drain_timeout_d;
            dma_start_q       <= dma_start_d;
            pixel_gate_q      <= pixel_gate_d;
            overrun_cnt_q     <= overrun_cnt_d;
            frames_captured_q <= frames_captured_d;
            drain_cnt_q       <= drain_cnt_d;
            win_cnt_q         <= win_cnt_d;
            fps_acc_q         <= fps_acc_d;
            fps_q             <= fps_d;
        end
    end

    assign dma_start         = dma_start_q;
    assign pixel_gate        = pixel_gate_q;
    assign frames_per_second = fps_q;
    assign cam_dma_status    = {frames_captured_q, overrun_cnt_q, 3'b000, pixel_gate_q,
                                drain_timeout_q, single_pending_q, state_q};
endmodule

// File: tb/tb_cam_capture_ctrl.sv
// tb_cam_capture_ctrl: scoreboarded bench for cam_capture_ctrl with short window and drain timeout
module tb_cam_capture_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trigger_capture_frame = 1'b0;
    logic        continuous_capture_frame = 1'b0;
    logic        cam_dma_init_done = 1'b0;
    logic        frame_start = 1'b0;
    logic        frame_end = 1'b0;
    logic        dma_done = 1'b0;
    logic        dma_start;
    logic        pixel_gate;
    logic [31:0] cam_dma_status;
    logic [31:0] frames_per_second;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int exp_q[$];

    cam_capture_ctrl #(.CLK_FREQ_HZ(1000), .DRAIN_TIMEOUT(16)) dut (
        .clk(clk),
        .reset(reset),
        .trigger_capture_frame(trigger_capture_frame),
        .continuous_capture_frame(continuous_capture_frame),
        .cam_dma_init_done(cam_dma_init_done),
        .frame_start(frame_start),
        .frame_end(frame_end),
        .dma_done(dma_done),
        .dma_start(dma_start),
        .pixel_gate(pixel_gate),
        .cam_dma_status(cam_dma_status),
        .frames_per_second(frames_per_second)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // one-cycle pulses; cap means this frame_start must yield dma_start two edges later
    task automatic step(input logic fs, input logic fe, input logic dd, input bit cap);
        frame_start = fs;
        frame_end   = fe;
        dma_done    = dd;
        if (cap) exp_q.push_back(cyc + 2);
        @(negedge clk);
        frame_start = 1'b0;
        frame_end   = 1'b0;
        dma_done    = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (dma_start) begin
            if (exp_q.size() == 0) check("dma_start_unexpected", 32'd1, 32'd0);
            else check("dma_start_cycle", cyc, exp_q.pop_front());
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not end, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        trigger_capture_frame = 1'b1;
        cam_dma_init_done     = 1'b1;
        @(negedge clk);
        do_reset();
        tick(4);
        check("rst_status", cam_dma_status, 32'h0);
        check("rst_fps", frames_per_second, 32'h0);
        check("rst_gate", {31'b0, pixel_gate}, 32'h0);
        trigger_capture_frame = 1'b0;
        tick(2);

        // single shot
        trigger_capture_frame = 1'b1;
        tick(2);
        check("ss_arm", cam_dma_status, 32'h0000_0005);
        tick(3);
        step(1, 0, 0, 1);
        tick(1);
        check("ss_capture", cam_dma_status, 32'h0000_0012);
        trigger_capture_frame = 1'b0;
        tick(20);
        step(0, 1, 0, 0);
        check("ss_drain_gate", cam_dma_status, 32'h0000_0013);
        tick(1);
        check("ss_gate_off", cam_dma_status, 32'h0000_0003);
        tick(3);
        step(0, 0, 1, 0);
        check("ss_done", cam_dma_status, 32'h0001_0000);
        step(1, 0, 0, 0);
        tick(5);
        check("ss_idle", cam_dma_status, 32'h0001_0000);

        // gating by init_done
        cam_dma_init_done     = 1'b0;
        trigger_capture_frame = 1'b1;
        tick(4);
        check("gate_pending", cam_dma_status, 32'h0001_0004);
        step(1, 0, 0, 0);
        tick(3);
        check("gate_hold", cam_dma_status, 32'h0001_0004);
        cam_dma_init_done = 1'b1;
        tick(2);
        check("gate_arm", cam_dma_status, 32'h0001_0005);
        step(1, 0, 0, 1);
        tick(10);
        step(0, 1, 0, 0);
        tick(2);
        step(0, 0, 1, 0);
        trigger_capture_frame = 1'b0;
        tick(2);
        check("gate_done", cam_dma_status, 32'h0002_0000);

        // continuous: dma_done lands on the next frame_start, so alternate frames are missed
        continuous_capture_frame = 1'b1;
        tick(2);
        check("cont_arm", cam_dma_status, 32'h0002_0001);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, i > 0, (i % 2) == 0);
            tick(8);
            step(0, 1, 0, 0);
            tick(3);
        end
        continuous_capture_frame = 1'b0;
        step(0, 0, 1, 0);
        check("cont_frames", cam_dma_status, 32'h0005_0000);
        step(1, 0, 0, 0);
        tick(4);
        check("cont_stop", cam_dma_status, 32'h0005_0000);

        // overrun and saturation
        continuous_capture_frame = 1'b1;
        tick(2);
        step(1, 0, 0, 1);
        tick(5);
        step(1, 0, 0, 0);
        check("ovr_first", cam_dma_status, 32'h0005_0113);
        tick(1);
        check("ovr_gate", cam_dma_status, 32'h0005_0103);
        step(0, 0, 1, 0);
        for (int i = 0; i < 299; i++) begin
            step(1, 0, 0, 1);
            tick(2);
            step(1, 0, 0, 0);
            step(0, 0, 1, 0);
        end
        continuous_capture_frame = 1'b0;
        tick(2);
        check("ovr_sat", cam_dma_status, 32'h0131_FF00);

        // drain timeout
        trigger_capture_frame = 1'b1;
        tick(3);
        check("to_arm", cam_dma_status, 32'h0131_FF05);
        step(1, 0, 0, 1);
        trigger_capture_frame = 1'b0;
        tick(4);
        step(0, 1, 0, 0);
        tick(15);
        check("to_wait", cam_dma_status, 32'h0131_FF03);
        tick(1);
        check("to_idle", cam_dma_status, 32'h0131_FF08);
        step(0, 0, 1, 0);
        tick(3);
        check("to_sticky", cam_dma_status, 32'h0131_FF08);
        do_reset();
        check("to_reset", cam_dma_status, 32'h0);

        // frame rate: a frame_start every 100 cycles, one of them in the wrap cycle
        for (int k = 0; k < 2500; k++) begin
            frame_start = (k % 100) == 99;
            if (k == 999) check("fps_first_window_open", frames_per_second, 32'd0);
            if (k == 1000) check("fps_window1", frames_per_second, 32'd10);
            if (k == 2000) check("fps_window2", frames_per_second, 32'd10);
            @(negedge clk);
        end
        frame_start = 1'b0;
        check("fps_pre_reset", frames_per_second, 32'd10);
        reset = 1'b1;
        tick(1);
        check("fps_reset", frames_per_second, 32'd0);
        reset = 1'b0;
        tick(2);

        check("sb_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
